uart_tx_sched: RTL and testbench

- Two-channel round-robin scheduler that shares one UART serial transmitter between two byte FIFOs.
- Pops one byte from the granted FIFO and serialises it as an 8N1 frame: start bit, DATA_W data bits LSB first, one stop bit.
- Sits between the channel TX FIFOs and the tx pin, and is the only reader of both FIFOs.

---
 rtl/uart_tx_sched.sv | 127 ++++++++++++
 tb/tb_uart_tx_sched.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one 8N1 UART transmitter between two byte FIFOs.
// One pop per frame from the granted FIFO; requests are sampled only while IDLE.
module uart_tx_sched #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ch0_empty,
  input  logic [DATA_W-1:0] ch0_data,
  output logic              ch0_rd_en,
  input  logic              ch1_empty,
  input  logic [DATA_W-1:0] ch1_data,
  output logic              ch1_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              grant_id,
  output logic              frame_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_e;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (en && (!ch0_empty || !ch1_empty)) begin
          // On a tie the channel that lost last time wins; a lone requester always wins.
          if (!ch0_empty && !ch1_empty) grant_d = ~last_q;
          else                          grant_d = ch0_empty;
          last_d  = grant_d;
          state_d = POP;
        end
      end
      POP: state_d = LOAD;
      LOAD: begin
        shift_d = grant_q ? ch1_data : ch0_data;
        baud_d  = '0;
        state_d = START;
      end
      START: begin
        baud_d = baud_q + BAUD_W'(1);
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        baud_d = baud_q + BAUD_W'(1);
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      STOP: begin
        baud_d = baud_q + BAUD_W'(1);
        if (baud_end) begin
          baud_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next state so the line changes exactly on bit boundaries.
    tx_d = 1'b1;
    if (state_d == START)     tx_d = 1'b0;
    else if (state_d == DATA) tx_d = shift_d[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign ch0_rd_en  = (state_q == POP) && !grant_q;
  assign ch1_rd_en  = (state_q == POP) &&  grant_q;
  assign grant_id   = grant_q;
  assign frame_done = (state_q == STOP) && baud_end;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with two behavioural byte FIFOs and CLKS_PER_BIT=4.
module tb_uart_tx_sched;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic       en;
  logic       ch0_empty, ch1_empty;
  logic [7:0] ch0_data, ch1_data;
  logic       ch0_rd_en, ch1_rd_en;
  logic       tx, busy, grant_id, frame_done;

  uart_tx_sched #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ch0_empty  (ch0_empty),
    .ch0_data   (ch0_data),
    .ch0_rd_en  (ch0_rd_en),
    .ch1_empty  (ch1_empty),
    .ch1_data   (ch1_data),
    .ch1_rd_en  (ch1_rd_en),
    .tx         (tx),
    .busy       (busy),
    .grant_id   (grant_id),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFOs: bench writes, DUT pops; read data valid the cycle after rd_en.
  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  int wp0 = 0, wp1 = 0, rp0 = 0, rp1 = 0;
  int pops0 = 0, pops1 = 0, bad_pops = 0;

  assign ch0_empty = (wp0 == rp0);
  assign ch1_empty = (wp1 == rp1);

  initial begin
    ch0_data = 8'h00;
    ch1_data = 8'h00;
  end

  always @(posedge clk) begin
    if ((ch0_rd_en && ch0_empty) || (ch1_rd_en && ch1_empty) || (ch0_rd_en && ch1_rd_en))
      bad_pops <= bad_pops + 1;
    if (ch0_rd_en) begin
      ch0_data <= mem0[rp0[3:0]];
      rp0      <= rp0 + 1;
      pops0    <= pops0 + 1;
    end
    if (ch1_rd_en) begin
      ch1_data <= mem1[rp1[3:0]];
      rp1      <= rp1 + 1;
      pops1    <= pops1 + 1;
    end
  end

  task automatic push0(input logic [7:0] d);
    mem0[wp0[3:0]] = d;
    wp0 = wp0 + 1;
  endtask

  task automatic push1(input logic [7:0] d);
    mem1[wp1[3:0]] = d;
    wp1 = wp1 + 1;
  endtask

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Waits for the pop, then checks LOAD, all ten bit slots, frame_done position and return to IDLE.
  // drop_bit >= 0 lowers en at the start of that data bit.
  task automatic do_frame(input logic eg, input logic [7:0] eb, input int drop_bit);
    int         lat;
    logic [9:0] expf, gotf;
    logic       unstable, fd_bad, idle_bad;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(ch0_rd_en || ch1_rd_en) && lat < 200);
    chk("pop_latency", lat, 1);
    chk("pop_strobe", {grant_id, ch1_rd_en, ch0_rd_en, busy}, {eg, eg, ~eg, 1'b1});

    @(negedge clk);
    chk("load_cycle", {tx, ch0_rd_en, ch1_rd_en, busy}, 4'b1001);

    expf     = {1'b1, eb, 1'b0};
    gotf     = '0;
    unstable = 1'b0;
    fd_bad   = 1'b0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (drop_bit >= 0 && b == drop_bit + 1 && c == 0) en = 1'b0;
        if (c == 0) gotf[b] = tx;
        else if (tx !== gotf[b]) unstable = 1'b1;
        if (frame_done !== (b == 9 && c == CPB - 1)) fd_bad = 1'b1;
        if (ch0_rd_en || ch1_rd_en || !busy) fd_bad = 1'b1;
      end
    end
    chk("frame_bits", gotf, expf);
    chk("bit_width", unstable, 0);
    chk("frame_done_pos", fd_bad, 0);

    @(negedge clk);
    idle_bad = busy || !tx || frame_done || ch0_rd_en || ch1_rd_en;
    chk("idle_after", idle_bad, 0);
  endtask

  typedef struct {
    logic       p0;
    logic [7:0] d0;
    logic       p1;
    logic [7:0] d1;
    logic       eg;
    logic [7:0] eb;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic bad;
    int   lat;

    tbl[0] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h11};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h44};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h22};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h55};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h33};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h66};
    tbl[6] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'hA5};
    tbl[7] = '{1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h5A};

    // Reset held with both FIFOs loaded: nothing may pop.
    rst = 1'b1;
    en  = 1'b1;
    push0(8'h11); push0(8'h22); push0(8'h33);
    push1(8'h44); push1(8'h55); push1(8'h66);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_state", {tx, busy, ch0_rd_en, ch1_rd_en, frame_done, grant_id}, 6'b100000);
    end
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].p0) push0(tbl[i].d0);
      if (tbl[i].p1) push1(tbl[i].d1);
      do_frame(tbl[i].eg, tbl[i].eb, -1);
    end

    // Only ch1 holds data: two back-to-back ch1 frames, one IDLE cycle apart.
    push1(8'h81);
    push1(8'h7E);
    do_frame(1'b1, 8'h81, -1);
    do_frame(1'b1, 8'h7E, -1);
    chk("ch0_pops_so_far", pops0, 5);

    // en dropped mid-DATA with a byte still pending.
    push0(8'hC3);
    push0(8'h96);
    do_frame(1'b0, 8'hC3, 2);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy || ch0_rd_en || ch1_rd_en || !tx) bad = 1'b1;
    end
    chk("hold_idle_en_low", bad, 0);
    en = 1'b1;
    do_frame(1'b0, 8'h96, -1);

    // Reset during data bit 3 of 0xE7 (bit 3 is 0).
    push0(8'hE7);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ch0_rd_en && lat < 200);
    chk("rst_frame_pop", {ch1_rd_en, ch0_rd_en}, 2'b01);
    repeat (19) @(negedge clk);
    chk("pre_rst_tx", {busy, tx}, 2'b10);
    rst = 1'b1;
    #1;
    chk("rst_async", {tx, busy, ch0_rd_en, ch1_rd_en, frame_done, grant_id}, 6'b100000);
    @(negedge clk);
    push0(8'h3A);
    rst = 1'b0;
    do_frame(1'b0, 8'h3A, -1);

    chk("bad_pops", bad_pops, 0);
    chk("ch0_pops_total", pops0, 9);
    chk("ch1_pops_total", pops1, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
    $fatal(1);
  end

endmodule
